dot_product_feeder: RTL and testbench
=====================================

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

Interface
REQ-001 SHALL have parameter N, default 8: element width in bits.
REQ-002 SHALL have parameter LAT, default 3: engine latency in clk edges from operands stable to dp_result valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  element pair offered.
REQ-006 SHALL have port in_ready  output  1  element pair accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port in_a  input  N  element of vector a.
REQ-008 SHALL have port in_b  input  N  element of vector b.
REQ-009 SHALL have port vec_a  output  4 x N (index 0..3)  operand array to the dot-product engine.
REQ-010 SHALL have port vec_b  output  4 x N (index 0..3)  operand array to the dot-product engine.
REQ-011 SHALL have port dp_result  input  4N  result from the engine.
REQ-012 SHALL have port res_valid  output  1  res_data holds a completed dot product.
REQ-013 SHALL have port res_ready  input  1  consumer takes res_data when res_valid && res_ready.
REQ-014 SHALL have port res_data  output  4N  captured dot product.
REQ-015 SHALL have port vec_count  output  8  completed-and-consumed vector count, wraps 255->0.

Function
REQ-016 SHALL implement FSM states FILL, WAIT, DONE.
REQ-017 In FILL, in_ready SHALL be 1; each accepted pair SHALL write in_a/in_b into vec_a/vec_b at index elem_idx, then elem_idx increments.
REQ-018 When the accepted pair has elem_idx==3, elem_idx SHALL wrap to 0, and FSM SHALL go to WAIT with wait_cnt=0.
REQ-019 In WAIT and DONE, in_ready SHALL be 0, in_valid SHALL be ignored, and vec_a/vec_b SHALL hold stable.
REQ-020 In WAIT, wait_cnt SHALL increment each edge; at the edge where wait_cnt==LAT, dp_result SHALL be captured into res_data, and FSM SHALL go to DONE.
REQ-021 Latency: if the 4th pair is accepted at edge E, res_valid SHALL rise after edge E+LAT+1.
REQ-022 In DONE, res_valid SHALL be 1, and res_data SHALL be stable until the handshake.
REQ-023 On the DONE handshake, FSM SHALL go to FILL and vec_count SHALL increment; in_ready SHALL rise the following cycle, with no same-cycle bypass.
REQ-024 res_valid held low (res_ready ignored) outside DONE.
REQ-025 res_data SHALL be dp_result verbatim: no truncation or sign handling; elements unsigned.
REQ-026 in_valid low mid-fill SHALL be allowed indefinitely; partial vector retained.

Reset
REQ-027 When rst=1 at an edge, the state SHALL be FILL, elem_idx=0, and wait_cnt=0.
REQ-028 When rst=1 at an edge, vec_a, vec_b, res_data, and vec_count SHALL be set to 0.
REQ-029 During reset and the cycle after, res_valid SHALL be 0 and in_ready SHALL be 1.
REQ-030 rst SHALL take priority over any handshake in the same cycle; a partial or in-flight vector SHALL be discarded.
REQ-031 Reset SHALL have no initial-block dependence; behaviour SHALL be defined by rst alone.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef (FILL/WAIT/DONE) and default constants for N and LAT.
REQ-033 The block SHALL be a single module with no sub-modules, and the wait counter width SHALL be $clog2(LAT+1).
REQ-034 The dot-product engine SHALL be instantiated beside the feeder in the top-level, not inside it.

Verification
REQ-035 Bench engine model: dp_result = sum of vec_a[i]*vec_b[i], delayed LAT edges, full 4N width.
REQ-036 Stimulus a=1,2,3,4 and b=5,6,7,8 back-to-back with res_ready=1 SHALL produce res_data=70 and res_valid high exactly LAT+1 cycles after the 4th accept, then vec_count=1.
REQ-037 All elements 255 SHALL produce res_data=260100.
REQ-038 res_ready held 0 for 10 cycles SHALL keep res_valid=1, res_data stable, and in_ready=0; in_valid pulses during that time SHALL not alter vec_a/vec_b.
REQ-039 in_valid gaps between elements SHALL give the same result as REQ-036, and vec_a/vec_b SHALL hold the partial contents during the gaps.
REQ-040 rst asserted after 2 accepted pairs and again in WAIT SHALL give all outputs zero, in_ready=1, and no res_valid; a subsequent full vector SHALL compute correctly.
REQ-041 256 consumed vectors SHALL make vec_count wrap to 0.

Source files
------------

// File: rtl/dot_product_feeder_pkg.sv
// Shared definitions for the dot-product feeder: FSM state encoding and
// default element width / engine latency.
package dot_product_feeder_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N   = 8;
  localparam int unsigned DEF_LAT = 3;

endpackage

// File: rtl/dot_product_feeder.sv
// Collects four element pairs into the engine operand arrays, waits out the
// engine latency, then holds the captured dot product until it is consumed.
module dot_product_feeder
  import dot_product_feeder_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned LAT = DEF_LAT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [N-1:0]   vec_a [0:3],
  output logic [N-1:0]   vec_b [0:3],
  input  logic [4*N-1:0] dp_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [4*N-1:0] res_data,
  output logic [7:0]     vec_count
);

  localparam int unsigned   CW      = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_CNT = CW'(LAT);

  state_t        state, state_nxt;
  logic [1:0]    elem_idx;
  logic [CW-1:0] wait_cnt;
  logic          accept, fire, consume;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    consume   = 1'b0;
    unique case (state)
      FILL: begin
        accept = in_valid;
        if (accept && elem_idx == 2'd3) state_nxt = WAIT;
      end
      WAIT: begin
        fire = (wait_cnt == LAT_CNT);
        if (fire) state_nxt = DONE;
      end
      DONE: begin
        consume = res_ready;
        if (consume) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Gated by rst so the handshake flags are defined even before the first edge.
  assign in_ready  = rst || (state == FILL);
  assign res_valid = !rst && (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_idx  <= '0;
      wait_cnt  <= '0;
      vec_a     <= '{default: '0};
      vec_b     <= '{default: '0};
      res_data  <= '0;
      vec_count <= '0;
    end else begin
      if (accept) begin
        vec_a[elem_idx] <= in_a;
        vec_b[elem_idx] <= in_b;
        elem_idx        <= elem_idx + 2'd1;
        wait_cnt        <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (fire)          res_data <= dp_result;
      if (consume)       vec_count <= vec_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: behavioural engine, scoreboard, vector table,
// directed corner sequences and a randomized run through the vec_count wrap.
module tb_dot_product_feeder;
  import dot_product_feeder_pkg::*;

  localparam int unsigned N   = DEF_N;
  localparam int unsigned LAT = DEF_LAT;
  localparam int unsigned RW  = 4 * N;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, res_valid, res_ready;
  logic [N-1:0]  in_a, in_b;
  logic [N-1:0]  vec_a [0:3];
  logic [N-1:0]  vec_b [0:3];
  logic [RW-1:0] dp_result, res_data;
  logic [7:0]    vec_count;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  always #5 clk = ~clk;

  dot_product_feeder #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .vec_a(vec_a), .vec_b(vec_b),
    .dp_result(dp_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .vec_count(vec_count)
  );

  // Engine: full-width sum of products, visible LAT edges after operands settle.
  function automatic logic [RW-1:0] dot4(input logic [N-1:0] a [0:3], input logic [N-1:0] b [0:3]);
    logic [RW-1:0] s = '0;
    for (int i = 0; i < 4; i++) s = s + RW'(a[2'(i)]) * RW'(b[2'(i)]);
    return s;
  endfunction

  logic [LAT-1:0][RW-1:0] pipe = '0;
  always @(posedge clk) pipe <= {pipe[LAT-2:0], dot4(vec_a, vec_b)};
  assign dp_result = pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Scoreboard: accepted pairs accumulate into sums; each consumed result
  // must match the oldest completed vector.
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] part_sum = '0;
  int unsigned   part_n   = 0;
  logic [7:0]    exp_cnt  = '0;
  int unsigned   consumed = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part_sum = '0;
      part_n   = 0;
      exp_cnt  = '0;
    end else begin
      if (in_valid && in_ready) begin
        part_sum = part_sum + RW'(in_a) * RW'(in_b);
        part_n++;
        if (part_n == 4) begin
          exp_q.push_back(part_sum);
          part_sum = '0;
          part_n   = 0;
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) fail("sb_unexpected_result", 64'(res_data), 64'(0));
        else check("sb_res_data", 64'(res_data), 64'(exp_q.pop_front()));
        check("sb_vec_count", 64'(vec_count), 64'(exp_cnt));
        exp_cnt++;
        consumed++;
      end
    end
  end

  typedef struct {
    logic [N-1:0]  a [4];
    logic [N-1:0]  b [4];
    logic [RW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, input int e);
    vec_t v;
    v.a[0] = N'(a0); v.a[1] = N'(a1); v.a[2] = N'(a2); v.a[3] = N'(a3);
    v.b[0] = N'(b0); v.b[1] = N'(b1); v.b[2] = N'(b2); v.b[3] = N'(b3);
    v.exp  = RW'(e);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned t = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail("send_timeout", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int j = 0; j < 4; j++) send_pair(v.a[2'(j)], v.b[2'(j)]);
  endtask

  // Returns at the negedge where res_valid is first seen high.
  task automatic await_result(input string name, input logic [RW-1:0] exp, input bit chk_lat);
    int unsigned cyc = 0;
    bit ok = 1'b0;
    while (cyc < 50 && !ok) begin
      @(negedge clk);
      cyc++;
      ok = res_valid;
    end
    if (!ok) fail({name, "_timeout"}, 64'(res_valid), 64'(1));
    else begin
      check({name, "_res_data"}, 64'(res_data), 64'(exp));
      check({name, "_in_ready_low"}, 64'(in_ready), 64'(0));
      if (chk_lat) check({name, "_latency"}, 64'(cyc - 1), 64'(LAT + 1));
    end
  endtask

  task automatic consume_check(input string name, input logic [7:0] exp_count);
    res_ready = 1'b1;
    tick();
    check({name, "_vec_count"}, 64'(vec_count), 64'(exp_count));
    check({name, "_in_ready_after"}, 64'(in_ready), 64'(1));
    check({name, "_res_valid_after"}, 64'(res_valid), 64'(0));
  endtask

  task automatic check_cleared(input string name);
    check({name, "_vec_a0"}, 64'(vec_a[0]), 64'(0));
    check({name, "_vec_a1"}, 64'(vec_a[1]), 64'(0));
    check({name, "_vec_b0"}, 64'(vec_b[0]), 64'(0));
    check({name, "_res_data"}, 64'(res_data), 64'(0));
    check({name, "_vec_count"}, 64'(vec_count), 64'(0));
    check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    check({name, "_res_valid"}, 64'(res_valid), 64'(0));
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    check({name, "_during_in_ready"}, 64'(in_ready), 64'(1));
    check({name, "_during_res_valid"}, 64'(res_valid), 64'(0));
    tick();
    rst = 1'b0;
    check_cleared(name);
  endtask

  vec_t        tbl [$];
  vec_t        v;
  logic [7:0]  dir_cnt;
  int unsigned guard;

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1; in_a = '0; in_b = '0;
    tick();
    pulse_reset("reset");
    dir_cnt = '0;

    tbl.push_back(mk(1, 2, 3, 4, 5, 6, 7, 8, 70));
    tbl.push_back(mk(255, 255, 255, 255, 255, 255, 255, 255, 260100));
    tbl.push_back(mk(0, 0, 0, 0, 9, 9, 9, 9, 0));
    tbl.push_back(mk(255, 0, 255, 0, 255, 255, 255, 255, 130050));
    tbl.push_back(mk(1, 1, 1, 1, 2, 3, 4, 5, 14));
    tbl.push_back(mk(200, 17, 3, 128, 100, 2, 250, 255, 53424));
    for (int k = 0; k < tbl.size(); k++) begin
      send_vec(tbl[k]);
      await_result("tbl", tbl[k].exp, 1'b1);
      dir_cnt++;
      consume_check("tbl", dir_cnt);
    end

    // Back-pressure: result and operands must hold while in_valid pulses.
    res_ready = 1'b0;
    v = mk(10, 20, 30, 40, 1, 2, 3, 4, 300);
    send_vec(v);
    await_result("bp", v.exp, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      in_valid = c[0];
      in_a = N'($urandom);
      in_b = N'($urandom);
      @(negedge clk);
      check("bp_res_valid", 64'(res_valid), 64'(1));
      check("bp_res_data", 64'(res_data), 64'(300));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_vec_a0", 64'(vec_a[0]), 64'(10));
      check("bp_vec_a3", 64'(vec_a[3]), 64'(40));
      check("bp_vec_b3", 64'(vec_b[3]), 64'(4));
    end
    tick();
    in_valid = 1'b0;
    dir_cnt++;
    consume_check("bp", dir_cnt);

    // Gaps between elements: partial vector must be retained.
    v = tbl[0];
    for (int j = 0; j < 4; j++) begin
      send_pair(v.a[2'(j)], v.b[2'(j)]);
      if (j < 3) begin
        repeat (3) tick();
        check("gap_vec_a", 64'(vec_a[2'(j)]), 64'(v.a[2'(j)]));
        check("gap_vec_b", 64'(vec_b[2'(j)]), 64'(v.b[2'(j)]));
        check("gap_in_ready", 64'(in_ready), 64'(1));
        check("gap_res_valid", 64'(res_valid), 64'(0));
      end
    end
    await_result("gap", 70, 1'b1);
    dir_cnt++;
    consume_check("gap", dir_cnt);

    // Reset after two pairs, then again while waiting on the engine.
    send_pair(8'd9, 8'd9);
    send_pair(8'd7, 8'd7);
    pulse_reset("rst_fill");
    v = mk(3, 3, 3, 3, 4, 4, 4, 4, 48);
    send_vec(v);
    tick();
    pulse_reset("rst_wait");
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      check("rst_wait_no_valid", 64'(res_valid), 64'(0));
    end
    tick();
    send_vec(tbl[0]);
    await_result("post_rst", 70, 1'b1);
    consume_check("post_rst", 8'd1);

    // Randomized traffic through 256 consumed vectors: vec_count wraps to 0.
    tick();
    pulse_reset("rand_start");
    consumed = 0;
    fork
      begin
        for (int k = 0; k < 1024; k++) begin
          logic [N-1:0] ra, rb;
          ra = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
          rb = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
          send_pair(ra, rb);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
      end
      begin
        guard = 0;
        while (consumed < 256 && guard < 30000) begin
          res_ready = ($urandom_range(0, 3) != 0);
          tick();
          guard++;
        end
        if (consumed < 256) fail("rand_consume_timeout", 64'(consumed), 64'(256));
        res_ready = 1'b1;
      end
    join
    repeat (2) tick();
    check("wrap_vec_count", 64'(vec_count), 64'(0));
    check("wrap_consumed", 64'(consumed), 64'(256));
    check("wrap_in_ready", 64'(in_ready), 64'(1));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout required completion");
    $display("%0d/%0d checks passed", pass_cnt, total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
